// File: rtl/prbs31_checker.sv
// -----------------------------------------------------------------------------
// prbs31_checker
// Serial PRBS31 (x^31 + x^28 + 1) receiver/checker. Self-synchronises to the
// incoming stream, declares lock after LOCK_CNT consecutive correct predictions,
// then free-runs its reference and counts bit errors and checked bits.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   rx_bit valid this cycle; nothing changes when low
//   rx_bit     in   received serial bit
//   clr        in   synchronous clear of err_cnt / bit_cnt
//   locked     out  synchronised to a PRBS31 stream
//   err_pulse  out  one-cycle strobe per detected bit error
//   err_cnt    out  saturating error count while locked   [ERR_W]
//   bit_cnt    out  saturating checked-bit count while locked [BIT_W]
// -----------------------------------------------------------------------------
module prbs31_checker #(
    parameter int LOCK_CNT    = 64,
    parameter int WIN         = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int ERR_W       = 16,
    parameter int BIT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rx_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN);
    localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [30:0]        hist_q, hist_d;
    logic [4:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               locked_q, locked_d;
    logic               pulse_q, pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic               pred_s;
    logic               err_s;
    logic [WERR_W-1:0]  werr_inc_s;

    // Prediction and the window error count including the current bit.
    always_comb begin
        pred_s     = hist_q[27] ^ hist_q[30];
        err_s      = rx_bit ^ pred_s;
        werr_inc_s = werr_q + WERR_W'(err_s);
    end

    // Next-state logic for the search/lock machine, history and counters.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        werr_d    = werr_q;
        pulse_d   = 1'b0;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;

        if (en) begin
            case (state_q)
                ST_SEARCH: begin
                    hist_d = {hist_q[29:0], rx_bit};
                    if (fill_q != 5'd31) begin
                        fill_d = fill_q + 5'd1;
                    end else if (!err_s && (hist_q != 31'd0)) begin
                        // An all-zero history predicts zero forever, so it is
                        // never allowed to count as a match.
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            match_d = {MATCH_W{1'b0}};
                            win_d   = {WIN_W{1'b0}};
                            werr_d  = {WERR_W{1'b0}};
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = {MATCH_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    // Reference free-runs: a line error is not fed back.
                    hist_d  = {hist_q[29:0], pred_s};
                    pulse_d = err_s;
                    if (bit_cnt_q != {BIT_W{1'b1}}) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                    if (err_s && (err_cnt_q != {ERR_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    win_d = win_q + WIN_W'(1);  // WIN is a power of two: wraps naturally
                    if (werr_inc_s == WERR_W'(UNLOCK_ERRS)) begin
                        state_d = ST_SEARCH;
                        fill_d  = 5'd0;
                        match_d = {MATCH_W{1'b0}};
                        win_d   = {WIN_W{1'b0}};
                        werr_d  = {WERR_W{1'b0}};
                    end else if (win_q == WIN_W'(WIN - 1)) begin
                        // The wrapping bit was already counted toward the closing window.
                        werr_d = {WERR_W{1'b0}};
                    end else begin
                        werr_d = werr_inc_s;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Clear wins over any same-cycle increment.
        if (clr) begin
            err_cnt_d = {ERR_W{1'b0}};
            bit_cnt_d = {BIT_W{1'b0}};
        end else begin
            err_cnt_d = err_cnt_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            hist_q    <= 31'd0;
            fill_q    <= 5'd0;
            match_q   <= {MATCH_W{1'b0}};
            win_q     <= {WIN_W{1'b0}};
            werr_q    <= {WERR_W{1'b0}};
            locked_q  <= 1'b0;
            pulse_q   <= 1'b0;
            err_cnt_q <= {ERR_W{1'b0}};
            bit_cnt_q <= {BIT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            locked_q  <= locked_d;
            pulse_q   <= pulse_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
Serial PRBS31 receiver/checker, the far end of the on-chip x^31+x^28+1 PRBS generator.
- Generator recurrence: 31-bit Fibonacci LFSR, feedback taps 27 and 30, serial output from bit 30.
- The checker self-synchronises to an incoming serial stream, declares lock, then counts bit errors and checked bits.
- Used for link and loopback bring-up on the tile pins: loop the generator output back to an input pin, and read results through the debug mux.

Parameters:
- LOCK_CNT, 64: consecutive correct predictions required (after history fill) to declare lock.
- WIN, 64: loss-of-lock observation window, in checked bits; power of two, 8..256.
- UNLOCK_ERRS, 8: errors within one window that force loss of lock; 1..WIN.
- ERR_W, 16: error counter width.
- BIT_W, 32: checked-bit counter width.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: rx_bit is valid this cycle; no state changes when low.
- rx_bit, input, 1: received serial bit.
- clr, input, 1: synchronous clear of err_cnt and bit_cnt.
- locked, output, 1: checker is synchronised to a PRBS31 stream.
- err_pulse, output, 1: one-cycle strobe for a detected bit error.
- err_cnt, output, ERR_W: saturating error count while locked.
- bit_cnt, output, BIT_W: saturating count of bits checked while locked.

Behaviour:
- Reset is asynchronous, active-low.
  - While rst_n is low: hist=0, fill=0, match=0, win=0, werr=0, state=SEARCH.
  - All outputs 0 immediately, without waiting for a clock edge.
  - Reset mid-operation discards lock and counts; there is no partial recovery.
- History register hist[30:0]: hist[0] is the most recent bit.
  - On each en cycle: hist <= {hist[29:0], s}, where s depends on state.
  - Prediction: p = hist[27] ^ hist[30]. This equals the generator's next output when hist holds its last 31 outputs.
- State SEARCH (locked=0), on each en cycle:
  - s = rx_bit (self-synchronising).
  - While fill < 31: fill increments; no comparison.
  - Once fill = 31: the bit is a match if rx_bit == p AND hist != 0.
  - A match increments match; a mismatch clears match to 0.
  - The all-zero history can never accumulate matches, so a stuck-at-0 line never locks.
  - When a match makes match reach LOCK_CNT: state <= LOCKED, and locked=1 from the next cycle. Also clear win and werr.
  - err_cnt, bit_cnt and err_pulse do not change in SEARCH.
- State LOCKED (locked=1), on each en cycle:
  - s = p. The reference free-runs, so one line error yields exactly one error, not three.
  - err = (rx_bit != p).
  - bit_cnt increments, saturating at all-ones.
  - On err: err_pulse=1 on the next cycle for one cycle; err_cnt increments, saturating at all-ones; werr increments.
  - win increments and wraps at WIN. On wrap, werr clears to 0; an error in the wrapping bit counts toward the window being closed.
  - If werr reaches UNLOCK_ERRS: state <= SEARCH, locked=0 next cycle; fill, match, win, werr clear.
  - hist and the counters hold their values when lock is lost.
  - Relock requires the full 31 + LOCK_CNT valid bits.
- en=0: nothing changes; err_pulse=0.
- clr:
  - Clears err_cnt and bit_cnt on the next edge.
  - Has priority over a same-cycle increment: the result is 0.
  - err_pulse and the lock state machine are unaffected.
- Latency: err_pulse and the counters are registered, one cycle after the en cycle carrying the bit.
- All outputs are driven directly from flops.

Test Plan:
1. Reset, then drive the generator stream (seed 1) with en=1 continuously → locked rises after bit 31+64=95; err_cnt=0; bit_cnt=N−95 after N bits.
2. Locked, invert one bit → exactly one err_pulse one cycle later; err_cnt=1; locked stays 1; no further errors over the next 200 bits.
3. Drive rx_bit=0 for 300 bits, then rx_bit=1 for 300 bits → locked never asserts; err_cnt=0.
4. Locked, inject 8 errors within one 64-bit window → locked falls the cycle after the 8th error; err_cnt=8; resume clean stream → relock after 95 bits. Same 8 errors split 4/4 across a window wrap → stays locked.
5. Random en duty cycle of about 50% with the clean stream → lock after 95 valid bits; bit_cnt equals the number of valid bits after lock; stalled cycles change nothing.
6. Locked with err_cnt=5, assert clr in the same cycle as an error → err_cnt=0 and err_pulse=1. Then drop rst_n mid-stream → locked, err_cnt, bit_cnt and err_pulse are 0 immediately.
